// File: rtl/div_unit_pkg.sv
// Shared types and constants for the radix-2 restoring divider used by ex for DIV/DIVU.
package div_unit_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider: one quotient bit per cycle, {remainder, quotient} result
// held registered until ex drops start_i.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int                CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [DATA_W-1:0] W_ZERO   = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] W_ONE    = {{(DATA_W-1){1'b0}}, 1'b1};

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
    return ~v + W_ONE;
  endfunction

  div_state_e              state_r,    state_nxt_s;
  logic [CNT_W-1:0]        cnt_r,      cnt_nxt_s;
  logic [2*DATA_W:0]       dividend_r, dividend_nxt_s;
  logic [DATA_W-1:0]       divisor_r,  divisor_nxt_s;
  logic                    neg_quot_r, neg_quot_nxt_s;
  logic                    neg_rem_r,  neg_rem_nxt_s;
  logic [2*DATA_W-1:0]     result_r,   result_nxt_s;
  logic                    ready_r,    ready_nxt_s;

  logic                    op1_neg_s;
  logic                    op2_neg_s;
  logic [DATA_W-1:0]       abs1_s;
  logic [DATA_W-1:0]       abs2_s;
  logic [DATA_W:0]         step_s;
  logic [DATA_W-1:0]       quot_s;
  logic [DATA_W-1:0]       rem_s;

  assign op1_neg_s = signed_div_i & opdata1_i[DATA_W-1];
  assign op2_neg_s = signed_div_i & opdata2_i[DATA_W-1];
  assign abs1_s    = op1_neg_s ? neg_w(opdata1_i) : opdata1_i;
  assign abs2_s    = op2_neg_s ? neg_w(opdata2_i) : opdata2_i;

  // Trial subtraction of the divisor from the partial remainder; bit DATA_W set means it went negative.
  assign step_s = {1'b0, dividend_r[2*DATA_W-1:DATA_W]} - {1'b0, divisor_r};

  // The remainder always takes the dividend's sign, so 0x80000000 / -1 simply wraps.
  assign quot_s = neg_quot_r ? neg_w(dividend_r[DATA_W-1:0]) : dividend_r[DATA_W-1:0];
  assign rem_s  = neg_rem_r  ? neg_w(dividend_r[2*DATA_W:DATA_W+1])
                             : dividend_r[2*DATA_W:DATA_W+1];

  // State register and datapath registers, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= DIV_FREE;
      cnt_r      <= CNT_ZERO;
      dividend_r <= {(2*DATA_W+1){1'b0}};
      divisor_r  <= W_ZERO;
      neg_quot_r <= 1'b0;
      neg_rem_r  <= 1'b0;
      result_r   <= {(2*DATA_W){1'b0}};
      ready_r    <= DIV_RESULT_NOT_READY;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      dividend_r <= dividend_nxt_s;
      divisor_r  <= divisor_nxt_s;
      neg_quot_r <= neg_quot_nxt_s;
      neg_rem_r  <= neg_rem_nxt_s;
      result_r   <= result_nxt_s;
      ready_r    <= ready_nxt_s;
    end
  end

  // Next-state and datapath update for each divider phase.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    dividend_nxt_s = dividend_r;
    divisor_nxt_s  = divisor_r;
    neg_quot_nxt_s = neg_quot_r;
    neg_rem_nxt_s  = neg_rem_r;
    result_nxt_s   = result_r;
    ready_nxt_s    = ready_r;

    case (state_r)
      DIV_FREE: begin
        result_nxt_s = {(2*DATA_W){1'b0}};
        ready_nxt_s  = DIV_RESULT_NOT_READY;
        if (start_i == DIV_START && annul_i == 1'b0) begin
          neg_quot_nxt_s = op1_neg_s ^ op2_neg_s;
          neg_rem_nxt_s  = op1_neg_s;
          divisor_nxt_s  = abs2_s;
          cnt_nxt_s      = CNT_ZERO;
          if (opdata2_i == W_ZERO) begin
            state_nxt_s = DIV_BYZERO;
          end else begin
            state_nxt_s    = DIV_ON;
            dividend_nxt_s = {W_ZERO, abs1_s, 1'b0};
          end
        end else begin
          state_nxt_s = DIV_FREE;
        end
      end

      DIV_BYZERO: begin
        dividend_nxt_s = {(2*DATA_W+1){1'b0}};
        neg_quot_nxt_s = 1'b0;
        neg_rem_nxt_s  = 1'b0;
        state_nxt_s    = DIV_END;
      end

      DIV_ON: begin
        if (annul_i == 1'b1) begin
          state_nxt_s  = DIV_FREE;
          cnt_nxt_s    = CNT_ZERO;
          result_nxt_s = {(2*DATA_W){1'b0}};
          ready_nxt_s  = DIV_RESULT_NOT_READY;
        end else if (cnt_r != CNT_LAST) begin
          if (step_s[DATA_W] == 1'b1) begin
            dividend_nxt_s = {dividend_r[2*DATA_W-1:0], 1'b0};
          end else begin
            dividend_nxt_s = {step_s[DATA_W-1:0], dividend_r[DATA_W-1:0], 1'b1};
          end
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else begin
          dividend_nxt_s = {rem_s, dividend_r[DATA_W], quot_s};
          cnt_nxt_s      = CNT_ZERO;
          state_nxt_s    = DIV_END;
        end
      end

      DIV_END: begin
        if (start_i == DIV_STOP) begin
          state_nxt_s  = DIV_FREE;
          result_nxt_s = {(2*DATA_W){1'b0}};
          ready_nxt_s  = DIV_RESULT_NOT_READY;
        end else begin
          result_nxt_s = {dividend_r[2*DATA_W:DATA_W+1], dividend_r[DATA_W-1:0]};
          ready_nxt_s  = DIV_RESULT_READY;
        end
      end

      default: begin
        state_nxt_s  = DIV_FREE;
        cnt_nxt_s    = CNT_ZERO;
        result_nxt_s = {(2*DATA_W){1'b0}};
        ready_nxt_s  = DIV_RESULT_NOT_READY;
      end
    endcase
  end

  assign result_o = result_r;
  assign ready_o  = ready_r;

endmodule
